// File: rtl/multi_can_counter.sv
// Multi-channel can counter: per-column stock, dispense handshake FSM driving a
// one-hot motor enable for a fixed number of cycles, low/empty flags, error
// pulses on rejected requests and a saturating total-sold counter.
module multi_can_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NCH         = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned LOW_THRESH  = 2,
    parameter int unsigned VEND_CYCLES = 3,
    parameter int unsigned SOLD_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [WIDTH-1:0]  count,
    input  logic              dispense,
    input  logic [CH_W-1:0]   disp_ch,
    output logic              busy,
    output logic [NCH-1:0]    vend,
    output logic              done,
    output logic              error,
    output logic [NCH-1:0]    empty,
    output logic [NCH-1:0]    low,
    output logic [SOLD_W-1:0] sold
);

    localparam int unsigned       CNT_W    = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(VEND_CYCLES - 1);
    localparam logic [CH_W:0]     NCH_L    = (CH_W + 1)'(NCH);
    localparam logic [WIDTH-1:0]  LOW_L    = WIDTH'(LOW_THRESH);
    localparam logic [SOLD_W-1:0] SOLD_MAX = {SOLD_W{1'b1}};
    localparam logic [NCH-1:0]    ONE_HOT0 = {{(NCH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StVend, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    stock_q [NCH];
    logic [WIDTH-1:0]    stock_d [NCH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // vend_q doubles as the latched channel for the in-flight dispense
    logic [NCH-1:0]      vend_q, vend_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [SOLD_W-1:0]   sold_q, sold_d;
    logic                load_ok, disp_ok, accept, reject, idle_req;

    // Request qualification; a load on the same edge suppresses any dispense
    always_comb begin
        load_ok  = load && ({1'b0, load_ch} < NCH_L);
        disp_ok  = 1'b0;
        if ({1'b0, disp_ch} < NCH_L) begin
            disp_ok = (stock_q[disp_ch] != '0);
        end
        idle_req = (state_q == StIdle) && !load && dispense;
        accept   = idle_req && disp_ok;
        reject   = idle_req && !disp_ok;
    end

    // Stock next-state: load wins, decrement only on an accepted (non-zero) dispense
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            stock_d[i] = stock_q[i];
        end
        if (load_ok) begin
            stock_d[load_ch] = count;
        end else if (accept) begin
            stock_d[disp_ch] = stock_q[disp_ch] - 1'b1;
        end
    end

    // Dispense FSM next-state and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vend_d  = '0;
        done_d  = 1'b0;
        error_d = reject;
        sold_d  = sold_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StVend;
                    cnt_d   = CNT_INIT;
                    vend_d  = ONE_HOT0 << disp_ch;
                    sold_d  = (sold_q == SOLD_MAX) ? sold_q : sold_q + 1'b1;
                end
            end
            StVend: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    vend_d = vend_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vend_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            sold_q  <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                stock_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vend_q  <= vend_d;
            done_q  <= done_d;
            error_q <= error_d;
            sold_q  <= sold_d;
            for (int i = 0; i < int'(NCH); i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    // Stock flags decoded from the registered counts
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            empty[i] = (stock_q[i] == '0);
            low[i]   = (stock_q[i] != '0) && (stock_q[i] <= LOW_L);
        end
    end

    assign busy  = (state_q != StIdle);
    assign vend  = vend_q;
    assign done  = done_q;
    assign error = error_q;
    assign sold  = sold_q;

endmodule

// File: doc/multi_can_counter.md
Name: multi_can_counter

Overview:
Parametrised multi-channel successor to the single-channel can counter. Tracks remaining stock for NCH vending columns. Runs a dispense handshake FSM that drives a one-hot motor-enable pulse of programmable length, then reports completion. Adds low-stock flags, error reporting on invalid or empty dispenses, and a saturating total-sold counter. Sits between the coin/selection controller and the column motor drivers.

Parameters:
WIDTH, 8, bits per channel stock counter
NCH, 4, number of channels (2..16)
CH_W, 2, channel-select width; must satisfy 2**CH_W >= NCH
LOW_THRESH, 2, low flag asserted when 1 <= stock <= LOW_THRESH
VEND_CYCLES, 3, cycles vend[] is held high per dispense (>=1)
SOLD_W, 16, width of total-sold counter

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
load  in  1  write count into channel load_ch this cycle
load_ch  in  CH_W  channel to load
count  in  WIDTH  stock value to load
dispense  in  1  dispense request, sampled only in IDLE
disp_ch  in  CH_W  channel to dispense from
busy  out  1  FSM not in IDLE
vend  out  NCH  one-hot motor enable, registered
done  out  1  one-cycle pulse, dispense complete
error  out  1  one-cycle pulse, request rejected
empty  out  NCH  empty[i] = (stock[i] == 0)
low  out  NCH  low[i] = (stock[i] != 0) && (stock[i] <= LOW_THRESH)
sold  out  SOLD_W  total accepted dispenses, saturating

Behaviour:
- Reset (async assert, sync release): all stock = 0, FSM = IDLE, busy/vend/done/error = 0, sold = 0. Hence empty = all 1s and low = 0.
- empty/low are combinational from the registered stock. busy/vend/done/error are registered.
- Load: on an edge with load=1 and load_ch < NCH, stock[load_ch] <= count. A load is legal in any FSM state, including onto the channel currently vending; the in-flight vend completes unaffected. load_ch >= NCH: load ignored, no error.
- FSM states: IDLE, VEND, DONE.
- IDLE, no load, dispense=1:
  - disp_ch >= NCH, or stock[disp_ch] == 0: error=1 next cycle; stay IDLE; stock and sold unchanged.
  - Otherwise accept: at that edge stock[disp_ch] decrements by 1, channel is latched, sold increments (holds at 2**SOLD_W-1), state -> VEND, busy=1, vend[ch]=1.
- IDLE with load=1 and dispense=1 on the same edge: load applies; dispense ignored on any channel; no error. The requester must re-present dispense.
- VEND: vend[ch] held for exactly VEND_CYCLES cycles (internal down-counter), then state -> DONE with vend=0, done=1.
- DONE: lasts one cycle; busy=1; next edge -> IDLE, busy=0, done=0.
- Accept-to-accept minimum spacing is VEND_CYCLES+2 cycles.
- dispense while busy is ignored silently: no error, no queueing.
- Stock never wraps. Decrement happens only after the non-zero check; 0 -> max is impossible.
- reset_n asserted mid-VEND: vend drops immediately (async) and all state returns to reset values.
- At most one vend bit is high at any time; vend == 0 whenever state != VEND.

Test Plan:
- Reset, then load ch2 count=5; dispense ch2 -> vend=4'b0100 for 3 cycles, done pulse on the 4th cycle, busy low on the 5th; stock[2]=4, sold=1, low[2]=0.
- Load ch0 count=1; dispense ch0 -> empty[0]=1 after the accept edge. Dispense ch0 again after done -> error pulse 1 cycle, sold unchanged, vend stays 0.
- Load ch1 count=3 -> low[1]=0. Dispense once -> stock 2, low[1]=1. Dispense twice more -> low[1]=0, empty[1]=1.
- Load+dispense same edge (load ch3=7, dispense ch1 with stock 2) -> stock[3]=7, stock[1] stays 2, busy stays 0, no error. Dispense held during VEND -> ignored, only one decrement.
- disp_ch=3 with NCH=3 -> error pulse; load_ch=3 -> no change. Load ch0 count=9 during vend of ch0 -> stock[0]=9, vend completes normally.
- Drop reset_n mid-VEND -> vend/busy=0 immediately, stock all 0, sold=0. With SOLD_W=2, 4 accepts -> sold saturates at 3.
